// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// ratio and the parity helper used by both the Rx and Tx sides.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP1     = 3'd4,
        RX_STOP2     = 3'd5,
        RX_WAIT_HIGH = 3'd6
    } rx_state_e;

    // len: 0 = 7 data bits, 1 = 8 data bits; mode: 0 = even, 1 = odd.
    function automatic logic par_bit(input logic [7:0] data, input logic len, input logic mode);
        logic [7:0] masked;
        masked = len ? data : {1'b0, data[6:0]};
        return (^masked) ^ mode;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so an
// idle-high serial line looks idle straight out of reset.
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling of 7/8 data
// bits, parity and 1/2 stop bits; delivers each frame as a one-cycle pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic       clk_rx,
    input  logic       reset,
    input  logic       enable,
    input  logic       d_num,
    input  logic       parity,
    input  logic       stop_bits,
    input  logic       Rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(OVERSAMPLE - 1);

    logic rx_s;

    uart_rx_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk_i (clk_rx),
        .rst_ni(reset),
        .d_i   (Rx),
        .q_o   (rx_s)
    );

    rx_state_e        state_q;
    logic [CNT_W-1:0] tick_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             d_num_q;
    logic             parity_q;
    logic             stop_bits_q;
    logic             perr_q;
    logic             ferr_q;
    logic [7:0]       data_q;
    logic             data_valid_q;
    logic             parity_err_q;
    logic             frame_err_q;
    logic             busy_q;

    logic [CNT_W-1:0] tick_d;
    logic [7:0]       shift_d;
    logic [2:0]       last_idx;
    logic             half_tick;
    logic             full_tick;

    assign tick_d    = tick_q + CNT_W'(1);
    assign half_tick = (tick_q == HALF_TICK);
    assign full_tick = (tick_q == FULL_TICK);
    assign last_idx  = d_num_q ? 3'd7 : 3'd6;

    always_comb begin
        shift_d            = shift_q;
        shift_d[bit_idx_q] = rx_s;
    end

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            state_q      <= RX_IDLE;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            d_num_q      <= 1'b0;
            parity_q     <= 1'b0;
            stop_bits_q  <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // Frame format is captured here so mid-frame changes are ignored.
                    if (enable && !rx_s) begin
                        state_q     <= RX_START;
                        tick_q      <= '0;
                        busy_q      <= 1'b1;
                        shift_q     <= '0;
                        d_num_q     <= d_num;
                        parity_q    <= parity;
                        stop_bits_q <= stop_bits;
                    end
                end
                RX_START: begin
                    if (half_tick) begin
                        tick_q <= '0;
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= RX_DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                RX_DATA: begin
                    if (full_tick) begin
                        tick_q  <= '0;
                        shift_q <= shift_d;
                        if (bit_idx_q == last_idx) begin
                            state_q <= RX_PARITY;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                RX_PARITY: begin
                    if (full_tick) begin
                        tick_q  <= '0;
                        perr_q  <= (rx_s != par_bit(shift_q, d_num_q, parity_q));
                        state_q <= RX_STOP1;
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                RX_STOP1: begin
                    if (full_tick) begin
                        tick_q <= '0;
                        ferr_q <= !rx_s;
                        if (stop_bits_q) begin
                            state_q <= RX_STOP2;
                        end else begin
                            data_q       <= d_num_q ? shift_q : {1'b0, shift_q[6:0]};
                            parity_err_q <= perr_q;
                            frame_err_q  <= !rx_s;
                            data_valid_q <= 1'b1;
                            state_q      <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                            busy_q       <= !rx_s;
                        end
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                RX_STOP2: begin
                    if (full_tick) begin
                        tick_q       <= '0;
                        data_q       <= d_num_q ? shift_q : {1'b0, shift_q[6:0]};
                        parity_err_q <= perr_q;
                        frame_err_q  <= ferr_q | !rx_s;
                        data_valid_q <= 1'b1;
                        state_q      <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                        busy_q       <= !rx_s;
                    end else begin
                        tick_q <= tick_d;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A low stop bit may be a break; wait for the line to recover.
                    if (rx_s) begin
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    tick_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frame driver, expected-result queue
// popped on each data_valid pulse, and a final pass/total report.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk_rx;
    logic       reset;
    logic       enable;
    logic       d_num;
    logic       parity;
    logic       stop_bits;
    logic       Rx;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];
    bit dv_seen = 1'b0;

    uart_rx #(
        .OVERSAMPLE(OS)
    ) dut (
        .clk_rx    (clk_rx),
        .reset     (reset),
        .enable    (enable),
        .d_num     (d_num),
        .parity    (parity),
        .stop_bits (stop_bits),
        .Rx        (Rx),
        .data      (data),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // clock / reset
    initial clk_rx = 1'b0;
    always #5 clk_rx = ~clk_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver tasks
    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (OS) @(negedge clk_rx);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic n8, input logic pmode,
                              input logic two_stop, input logic flip_par,
                              input logic stop2_low, input logic expect_it);
        logic [7:0] exp_d;
        logic       exp_par;
        exp_d   = n8 ? d : {1'b0, d[6:0]};
        exp_par = (^exp_d) ^ pmode;
        if (expect_it) exp_q.push_back({exp_d, flip_par, two_stop & stop2_low});
        d_num     = n8;
        parity    = pmode;
        stop_bits = two_stop;
        drive_bit(1'b0);
        for (int i = 0; i < (n8 ? 8 : 7); i++) drive_bit(d[i]);
        drive_bit(exp_par ^ flip_par);
        drive_bit(1'b1);
        if (two_stop) drive_bit(!stop2_low);
    endtask

    // scoreboard
    always @(negedge clk_rx) begin
        logic [9:0] e;
        if (dv_seen) begin
            check("dv_width", data_valid, 0);
            dv_seen = 1'b0;
        end
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dv", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", data, e[9:2]);
                check("parity_err", parity_err, e[1]);
                check("frame_err", frame_err, e[0]);
            end
            dv_seen = 1'b1;
        end
    end

    initial begin
        int hcnt;
        reset     = 1'b0;
        enable    = 1'b0;
        d_num     = 1'b1;
        parity    = 1'b0;
        stop_bits = 1'b0;
        Rx        = 1'b1;
        repeat (3) @(negedge clk_rx);
        check("rst_data", data, 0);
        check("rst_dv", data_valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        reset  = 1'b1;
        enable = 1'b1;
        idle(4);

        // 8N1-even 0xA5 with busy observed mid-frame and after the stop bit
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (80) @(negedge clk_rx);
                check("a5_busy_mid", busy, 1);
            end
        join
        check("a5_busy_end", busy, 0);
        idle(16);

        // 7-bit odd parity; format inputs and enable disturbed mid-frame
        fork
            send_frame(8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk_rx);
                enable    = 1'b0;
                d_num     = 1'b1;
                parity    = 1'b0;
                stop_bits = 1'b1;
            end
        join
        check("cfg_busy_end", busy, 0);
        enable = 1'b1;
        idle(16);

        // parity bit flipped
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(16);

        // second stop bit low, line held low (break)
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        Rx = 1'b0;
        repeat (40) @(negedge clk_rx);
        check("break_busy_low", busy, 1);
        Rx = 1'b1;
        repeat (5) @(negedge clk_rx);
        check("break_busy_release", busy, 0);
        idle(3 * OS);

        // 4-cycle glitch on an idle line
        hcnt = 0;
        Rx   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_rx);
            if (i == 3) Rx = 1'b1;
            if (busy) hcnt++;
        end
        check("glitch_busy_seen", (hcnt > 0), 1);
        check("glitch_busy_len", (hcnt <= OS / 2 + 2), 1);
        check("glitch_busy_end", busy, 0);
        idle(8);

        // reset asserted while in DATA; nothing expected for the aborted frame
        d_num = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (5) @(negedge clk_rx);
        reset = 1'b0;
        Rx    = 1'b1;
        repeat (2) @(negedge clk_rx);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data, 0);
        reset = 1'b1;
        idle(3 * OS);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back frames
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);

        // random formats and payloads
        for (int k = 0; k < 6; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0, 1'b1);
            idle($urandom_range(0, 20));
        end

        idle(2 * OS);
        check("pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the team's Tx block. Recovers frames from the serial line: start bit (0), 7 or 8 data bits LSB first, one parity bit, then 1 or 2 stop bits (1). Runs from an oversampled clock, samples each bit at mid-point, and delivers the byte with parity/framing status as a one-cycle valid pulse to the downstream consumer.

Parameters:
OVERSAMPLE, 16, clk_rx cycles per bit period; even, >=4
CNT_W, $clog2(OVERSAMPLE), width of the sample-tick counter

Ports:
clk_rx  input  1  receive clock, OVERSAMPLE x baud
reset  input  1  asynchronous, active-low reset
enable  input  1  permits detection of a new start bit
d_num  input  1  0: 7 data bits, 1: 8 data bits
parity  input  1  parity mode; expected parity bit = (^data_bits) ^ parity (0 even, 1 odd)
stop_bits  input  1  0: one stop bit, 1: two stop bits
Rx  input  1  serial line, idle high, asynchronous to clk_rx
data  output  8  received data; bit 7 = 0 in 7-bit mode
data_valid  output  1  one-cycle pulse, frame complete
parity_err  output  1  parity mismatch on the frame; valid with data_valid
frame_err  output  1  a stop bit sampled low; valid with data_valid
busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0, data=0, data_valid=0, parity_err=0, frame_err=0, busy=0. Synchronizer flops reset to 1. Reset mid-frame aborts the frame with no data_valid.
- Rx passes through a 2-FF synchronizer (reset value 1). All logic below uses the synchronized value rx_s. Latency: 2 cycles.
- d_num, parity and stop_bits are latched at start detection and held for the frame. Changes mid-frame have no effect.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: if enable and rx_s==0, go to START, set tick=0 and busy=1. If enable=0, stay in IDLE.
- START: at tick==OVERSAMPLE/2-1, sample rx_s. If 1 (false start, glitch), go to IDLE with busy=0 and no outputs. If 0, go to DATA with tick=0, bit_idx=0.
- Sampling in all later states happens at tick==OVERSAMPLE-1, which is the mid-point of each bit. tick wraps to 0 on each sample.
- DATA: shift the sample into bit position bit_idx. After bit 6 (7-bit mode) or bit 7 (8-bit mode), go to PARITY. In 7-bit mode, bit 7 of the shift register is forced to 0.
- PARITY: compute perr = sample != (^shift_reg ^ parity_l). Go to STOP1.
- STOP1: ferr = (sample==0).
  - With one stop bit, finish.
  - With two stop bits, go to STOP2.
- STOP2: ferr |= (sample==0), then finish.
- Finish: in the cycle after the final stop-bit sample:
  - data, parity_err and frame_err register the frame values.
  - data_valid=1 for exactly one cycle.
  - data and the error flags hold until the next finish.
  - If the final stop sample was 0, go to WAIT_HIGH; otherwise go to IDLE with busy=0.
- WAIT_HIGH (break/framing recovery): stay until rx_s==1, then go to IDLE and drop busy. No start detection happens while in WAIT_HIGH.
- Deasserting enable mid-frame does not abort; the frame completes normally.
- Back-to-back frames: a start bit that follows the stop sample by half a bit is detected. No dead cycles beyond the IDLE check.
- Illegal state encoding: go to IDLE.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum
  - default OVERSAMPLE
  - the shared parity function par_bit(data, len, mode), which the Tx side can also use
- Sub-module uart_rx_sync: parameterised 2-FF synchronizer with reset value 1.

Test Plan:
- OVERSAMPLE=16, d_num=1, parity=0, stop_bits=0; send 0xA5 with parity bit 0 -> data=0xA5, data_valid single pulse, parity_err=0, frame_err=0, and busy falls after the stop bit.
- d_num=0, parity=1; send 7-bit 0x35 with parity bit 1 -> data=0x35 with bit 7=0, and no errors.
- Same frame as the 0xA5 case with the parity bit flipped to 1 -> data=0xA5, parity_err=1, frame_err=0.
- stop_bits=1; send 0x3C with the second stop bit low, then the line held low 40 cycles -> frame_err=1 and one data_valid; busy stays high in WAIT_HIGH until the line returns high, and no spurious frame follows.
- Low glitch of 4 cycles on an idle line -> no data_valid, and busy returns to 0 within OVERSAMPLE/2+2 cycles.
- Assert reset mid-DATA, then release and send 0x5A -> no pulse for the aborted frame, and the next frame gives data=0x5A cleanly; back-to-back frames 0x01 then 0xFE -> two pulses with correct data.
